// File: rtl/exe_up_branch_resolve.sv
// exe_up_branch_resolve
// Upper-lane execute stage: resolves the branch held in EXE_up (direction,
// target, link value, repair action against the front-end prediction) and
// registers the results for the second-stage branch-amend block in PREMEM.
// One valid/allowin pipeline segment, plus a saturating mispredict counter.
//
// Exception segment encoding (one bit per pipeline segment, youngest first):
//   bit0 IF, bit1 ID, bit2 ISS, bit3 EXE, bit4 PREMEM, bit5 MEM, bit6 WB.
// An exception taken in EXE or any older segment kills this stage.
module exe_up_branch_resolve #(
  parameter int CKPT_W      = 32,
  parameter int REPAIR_W    = 4,
  parameter int EXCEP_SEG_W = 7,
  parameter logic [EXCEP_SEG_W-1:0] EXCEP_KILL_MASK = 7'b111_1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ISS_valid_w_i,
  input  logic [31:0]            ISS_VAddr_i,
  input  logic [4:0]             ISS_writeNum_i,
  input  logic [31:0]            ISS_rsVal_i,
  input  logic [31:0]            ISS_rtVal_i,
  input  logic [3:0]             ISS_brType_i,
  input  logic [25:0]            ISS_imm26_i,
  input  logic [31:0]            ISS_aluRes_i,
  input  logic                   ISS_predTake_i,
  input  logic [31:0]            ISS_predDest_i,
  input  logic [CKPT_W-1:0]      ISS_checkPoint_i,
  input  logic                   SBA_allowin_w_i,
  input  logic                   SBA_flush_w_i,
  input  logic                   CP0_excOccur_w_i,
  input  logic [EXCEP_SEG_W-1:0] CP0_exceptSeg_w_i,
  output logic                   EXU_allowin_w_o,
  output logic                   EXU_valid_w_o,
  output logic [4:0]             EXE_up_writeNum_o,
  output logic [31:0]            EXE_up_VAddr_o,
  output logic [31:0]            EXE_up_aluRes_o,
  output logic [31:0]            EXE_up_corrDest_o,
  output logic                   EXE_up_corrTake_o,
  output logic [REPAIR_W-1:0]    EXE_up_repairAction_o,
  output logic [CKPT_W-1:0]      EXE_up_checkPoint_o,
  output logic                   EXE_up_branchRisk_o,
  output logic [31:0]            EXU_mispredCnt_o
);

  localparam logic [3:0] BR_BEQ    = 4'd1;
  localparam logic [3:0] BR_BNE    = 4'd2;
  localparam logic [3:0] BR_BLEZ   = 4'd3;
  localparam logic [3:0] BR_BGTZ   = 4'd4;
  localparam logic [3:0] BR_BLTZ   = 4'd5;
  localparam logic [3:0] BR_BGEZ   = 4'd6;
  localparam logic [3:0] BR_BLTZAL = 4'd7;
  localparam logic [3:0] BR_BGEZAL = 4'd8;
  localparam logic [3:0] BR_J      = 4'd9;
  localparam logic [3:0] BR_JAL    = 4'd10;
  localparam logic [3:0] BR_JR     = 4'd11;
  localparam logic [3:0] BR_JALR   = 4'd12;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  // Repair action: bit0 need_repair, bit1 direction wrong, bit2 target wrong,
  // bit3 link write. Non-branches never request repair.
  function automatic logic [REPAIR_W-1:0] calc_repair(
    input logic        is_branch,
    input logic        corr_take,
    input logic [31:0] corr_dest,
    input logic        pred_take,
    input logic [31:0] pred_dest,
    input logic        is_link
  );
    logic [REPAIR_W-1:0] r;
    r = {REPAIR_W{1'b0}};
    if (is_branch) begin
      r[1] = (pred_take != corr_take);
      r[2] = corr_take && (pred_dest != corr_dest);
      r[0] = r[1] | r[2];
      r[3] = is_link;
    end else begin
      r = {REPAIR_W{1'b0}};
    end
    return r;
  endfunction

  // Stage state
  logic                has_data_q,    has_data_d;
  logic [4:0]          write_num_q,   write_num_d;
  logic [31:0]         vaddr_q,       vaddr_d;
  logic [31:0]         alu_res_q,     alu_res_d;
  logic [31:0]         corr_dest_q,   corr_dest_d;
  logic                corr_take_q,   corr_take_d;
  logic [REPAIR_W-1:0] repair_q,      repair_d;
  logic [CKPT_W-1:0]   ckpt_q,        ckpt_d;
  logic                branch_risk_q, branch_risk_d;
  logic [31:0]         mispred_cnt_q, mispred_cnt_d;

  // Resolve signals
  logic [31:0]         pc_plus4_s;
  logic [31:0]         pc_plus8_s;
  logic [31:0]         br_tgt_s;
  logic [31:0]         jmp_tgt_s;
  logic [31:0]         target_s;
  logic                is_branch_s;
  logic                is_link_s;
  logic                taken_s;
  logic [31:0]         corr_dest_s;
  logic [31:0]         alu_res_s;
  logic [REPAIR_W-1:0] repair_s;
  logic                kill_s;
  logic                allowin_s;
  logic                accept_s;

  // Candidate targets and fall-through addresses for the issuing instruction.
  always_comb begin
    pc_plus4_s = ISS_VAddr_i + 32'd4;
    pc_plus8_s = ISS_VAddr_i + 32'd8;
    br_tgt_s   = pc_plus4_s + {{14{ISS_imm26_i[15]}}, ISS_imm26_i[15:0], 2'b00};
    jmp_tgt_s  = {pc_plus4_s[31:28], ISS_imm26_i, 2'b00};
  end

  // Decode the branch type into direction, target and link behaviour.
  always_comb begin
    is_branch_s = 1'b0;
    is_link_s   = 1'b0;
    taken_s     = 1'b0;
    target_s    = pc_plus8_s;
    case (ISS_brType_i)
      BR_BEQ: begin
        is_branch_s = 1'b1;
        taken_s     = (ISS_rsVal_i == ISS_rtVal_i);
        target_s    = br_tgt_s;
      end
      BR_BNE: begin
        is_branch_s = 1'b1;
        taken_s     = (ISS_rsVal_i != ISS_rtVal_i);
        target_s    = br_tgt_s;
      end
      BR_BLEZ: begin
        is_branch_s = 1'b1;
        taken_s     = ISS_rsVal_i[31] || (ISS_rsVal_i == 32'd0);
        target_s    = br_tgt_s;
      end
      BR_BGTZ: begin
        is_branch_s = 1'b1;
        taken_s     = !ISS_rsVal_i[31] && (ISS_rsVal_i != 32'd0);
        target_s    = br_tgt_s;
      end
      BR_BLTZ, BR_BLTZAL: begin
        is_branch_s = 1'b1;
        is_link_s   = (ISS_brType_i == BR_BLTZAL);
        taken_s     = ISS_rsVal_i[31];
        target_s    = br_tgt_s;
      end
      BR_BGEZ, BR_BGEZAL: begin
        is_branch_s = 1'b1;
        is_link_s   = (ISS_brType_i == BR_BGEZAL);
        taken_s     = !ISS_rsVal_i[31];
        target_s    = br_tgt_s;
      end
      BR_J, BR_JAL: begin
        is_branch_s = 1'b1;
        is_link_s   = (ISS_brType_i == BR_JAL);
        taken_s     = 1'b1;
        target_s    = jmp_tgt_s;
      end
      BR_JR, BR_JALR: begin
        is_branch_s = 1'b1;
        is_link_s   = (ISS_brType_i == BR_JALR);
        taken_s     = 1'b1;
        target_s    = ISS_rsVal_i;
      end
      default: begin
        is_branch_s = 1'b0;
        is_link_s   = 1'b0;
        taken_s     = 1'b0;
        target_s    = pc_plus8_s;
      end
    endcase
  end

  // Corrected destination, link value, repair action and handshake terms.
  always_comb begin
    corr_dest_s = taken_s ? target_s : pc_plus8_s;
    alu_res_s   = is_link_s ? pc_plus8_s : ISS_aluRes_i;
    repair_s    = calc_repair(is_branch_s, taken_s, corr_dest_s,
                              ISS_predTake_i, ISS_predDest_i, is_link_s);
    kill_s      = SBA_flush_w_i ||
                  (CP0_excOccur_w_i && (|(CP0_exceptSeg_w_i & EXCEP_KILL_MASK)));
    allowin_s   = !has_data_q || SBA_allowin_w_i;
    accept_s    = ISS_valid_w_i && allowin_s && !kill_s;
  end

  // Next-state for the stage: kill clears, allowin loads/empties, else hold.
  always_comb begin
    has_data_d    = has_data_q;
    write_num_d   = write_num_q;
    vaddr_d       = vaddr_q;
    alu_res_d     = alu_res_q;
    corr_dest_d   = corr_dest_q;
    corr_take_d   = corr_take_q;
    repair_d      = repair_q;
    ckpt_d        = ckpt_q;
    branch_risk_d = branch_risk_q;
    if (kill_s) begin
      has_data_d    = 1'b0;
      write_num_d   = 5'd0;
      vaddr_d       = 32'd0;
      alu_res_d     = 32'd0;
      corr_dest_d   = 32'd0;
      corr_take_d   = 1'b0;
      repair_d      = {REPAIR_W{1'b0}};
      ckpt_d        = {CKPT_W{1'b0}};
      branch_risk_d = 1'b0;
    end else if (allowin_s) begin
      has_data_d = accept_s;
      if (accept_s) begin
        write_num_d   = ISS_writeNum_i;
        vaddr_d       = ISS_VAddr_i;
        alu_res_d     = alu_res_s;
        corr_dest_d   = corr_dest_s;
        corr_take_d   = taken_s;
        repair_d      = repair_s;
        ckpt_d        = ISS_checkPoint_i;
        branch_risk_d = is_branch_s;
      end else begin
        has_data_d = 1'b0;
      end
    end else begin
      has_data_d = has_data_q;
    end
  end

  // Saturating count of accepted instructions that need repair.
  always_comb begin
    if (accept_s && repair_s[0] && (mispred_cnt_q != CNT_MAX)) begin
      mispred_cnt_d = mispred_cnt_q + 32'd1;
    end else begin
      mispred_cnt_d = mispred_cnt_q;
    end
  end

  // Stage and counter registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      has_data_q    <= 1'b0;
      write_num_q   <= 5'd0;
      vaddr_q       <= 32'd0;
      alu_res_q     <= 32'd0;
      corr_dest_q   <= 32'd0;
      corr_take_q   <= 1'b0;
      repair_q      <= {REPAIR_W{1'b0}};
      ckpt_q        <= {CKPT_W{1'b0}};
      branch_risk_q <= 1'b0;
      mispred_cnt_q <= 32'd0;
    end else begin
      has_data_q    <= has_data_d;
      write_num_q   <= write_num_d;
      vaddr_q       <= vaddr_d;
      alu_res_q     <= alu_res_d;
      corr_dest_q   <= corr_dest_d;
      corr_take_q   <= corr_take_d;
      repair_q      <= repair_d;
      ckpt_q        <= ckpt_d;
      branch_risk_q <= branch_risk_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign EXU_allowin_w_o       = allowin_s;
  assign EXU_valid_w_o         = has_data_q && !kill_s;
  assign EXE_up_writeNum_o     = write_num_q;
  assign EXE_up_VAddr_o        = vaddr_q;
  assign EXE_up_aluRes_o       = alu_res_q;
  assign EXE_up_corrDest_o     = corr_dest_q;
  assign EXE_up_corrTake_o     = corr_take_q;
  assign EXE_up_repairAction_o = repair_q;
  assign EXE_up_checkPoint_o   = ckpt_q;
  assign EXE_up_branchRisk_o   = branch_risk_q;
  assign EXU_mispredCnt_o      = mispred_cnt_q;

endmodule

// File: tb/tb_exe_up_branch_resolve.sv
// Bench for exe_up_branch_resolve: directed cases plus randomized traffic,
// checked through a per-cycle expectation queue and a separate monitor.
module tb_exe_up_branch_resolve;

  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
    logic [4:0]  wn;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [3:0]  bt;
    logic [25:0] imm;
    logic [31:0] alu;
    logic        pt;
    logic [31:0] pd;
    logic [31:0] ck;
    logic        sba;
    logic        flush;
    logic        exc;
    logic [6:0]  seg;
  } stim_t;

  typedef struct packed {
    logic [4:0]  wn;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] dest;
    logic        take;
    logic [3:0]  rep;
    logic [31:0] ck;
    logic        risk;
  } out_t;

  typedef struct packed {
    logic        allowin;
    logic        valid;
    out_t        regs;
    logic [31:0] cnt;
  } rec_t;

  logic clk = 1'b0;
  logic rst;
  logic        iss_valid, iss_predTake, sba_allowin, sba_flush, cp0_exc;
  logic [31:0] iss_vaddr, iss_rs, iss_rt, iss_alu, iss_predDest, iss_ckpt;
  logic [4:0]  iss_wn;
  logic [3:0]  iss_bt;
  logic [25:0] iss_imm;
  logic [6:0]  cp0_seg;
  logic        exu_allowin, exu_valid, o_take, o_risk;
  logic [4:0]  o_wn;
  logic [31:0] o_pc, o_alu, o_dest, o_ck, o_cnt;
  logic [3:0]  o_rep;

  int n_checks = 0;
  int n_fail   = 0;

  rec_t  rec_q[$];
  rec_t  mon_r;
  logic  m_full;
  out_t  m_regs;
  logic [31:0] m_cnt;

  exe_up_branch_resolve dut (
    .clk(clk), .rst(rst),
    .ISS_valid_w_i(iss_valid), .ISS_VAddr_i(iss_vaddr), .ISS_writeNum_i(iss_wn),
    .ISS_rsVal_i(iss_rs), .ISS_rtVal_i(iss_rt), .ISS_brType_i(iss_bt),
    .ISS_imm26_i(iss_imm), .ISS_aluRes_i(iss_alu), .ISS_predTake_i(iss_predTake),
    .ISS_predDest_i(iss_predDest), .ISS_checkPoint_i(iss_ckpt),
    .SBA_allowin_w_i(sba_allowin), .SBA_flush_w_i(sba_flush),
    .CP0_excOccur_w_i(cp0_exc), .CP0_exceptSeg_w_i(cp0_seg),
    .EXU_allowin_w_o(exu_allowin), .EXU_valid_w_o(exu_valid),
    .EXE_up_writeNum_o(o_wn), .EXE_up_VAddr_o(o_pc), .EXE_up_aluRes_o(o_alu),
    .EXE_up_corrDest_o(o_dest), .EXE_up_corrTake_o(o_take),
    .EXE_up_repairAction_o(o_rep), .EXE_up_checkPoint_o(o_ck),
    .EXE_up_branchRisk_o(o_risk), .EXU_mispredCnt_o(o_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference resolve written straight from the architectural rules.
  function automatic out_t resolve(input stim_t s);
    out_t o;
    logic [31:0] nxt, fall, tgt;
    logic signed [15:0] off;
    int signed rsv;
    logic br, link, taken;
    nxt  = s.pc + 32'd4;
    fall = s.pc + 32'd8;
    off  = s.imm[15:0];
    rsv  = s.rs;
    br   = (s.bt >= 4'd1) && (s.bt <= 4'd12);
    link = (s.bt == 4'd7) || (s.bt == 4'd8) || (s.bt == 4'd10) || (s.bt == 4'd12);
    if (s.bt <= 4'd8)       tgt = nxt + 32'(int'(off) * 4);
    else if (s.bt <= 4'd10) tgt = {nxt[31:28], s.imm, 2'b00};
    else                    tgt = s.rs;
    taken = 1'b0;
    if (s.bt == 4'd1) taken = (s.rs == s.rt);
    if (s.bt == 4'd2) taken = (s.rs != s.rt);
    if (s.bt == 4'd3) taken = (rsv <= 0);
    if (s.bt == 4'd4) taken = (rsv > 0);
    if (s.bt == 4'd5 || s.bt == 4'd7) taken = (rsv < 0);
    if (s.bt == 4'd6 || s.bt == 4'd8) taken = (rsv >= 0);
    if (s.bt >= 4'd9 && s.bt <= 4'd12) taken = 1'b1;
    o.wn   = s.wn;
    o.pc   = s.pc;
    o.take = taken;
    o.dest = taken ? tgt : fall;
    o.alu  = link ? fall : s.alu;
    o.ck   = s.ck;
    o.risk = br;
    o.rep  = 4'd0;
    if (br) begin
      o.rep[1] = (s.pt != taken);
      o.rep[2] = taken && (s.pd != o.dest);
      o.rep[0] = o.rep[1] || o.rep[2];
      o.rep[3] = link;
    end
    return o;
  endfunction

  // One clock of stimulus: apply inputs, queue this cycle's expectation, advance model.
  task automatic drive(input stim_t s);
    rec_t r;
    out_t res;
    logic kill, allow, acc;
    @(posedge clk);
    #1;
    iss_valid = s.vld;  iss_vaddr = s.pc;  iss_wn = s.wn;  iss_rs = s.rs;
    iss_rt = s.rt;  iss_bt = s.bt;  iss_imm = s.imm;  iss_alu = s.alu;
    iss_predTake = s.pt;  iss_predDest = s.pd;  iss_ckpt = s.ck;
    sba_allowin = s.sba;  sba_flush = s.flush;  cp0_exc = s.exc;  cp0_seg = s.seg;
    kill  = s.flush || (s.exc && (s.seg[3] || s.seg[4] || s.seg[5] || s.seg[6]));
    allow = !m_full || s.sba;
    r.allowin = allow;
    r.valid   = m_full && !kill;
    r.regs    = m_regs;
    r.cnt     = m_cnt;
    rec_q.push_back(r);
    acc = s.vld && allow && !kill;
    res = resolve(s);
    if (kill) begin
      m_full = 1'b0;
      m_regs = '0;
    end else if (allow) begin
      m_full = acc;
      if (acc) m_regs = res;
    end
    if (acc && res.rep[0] && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.sba = 1'b1;
    return s;
  endfunction

  function automatic stim_t br_stim(input logic [31:0] pc, input logic [3:0] bt,
                                    input logic [31:0] rs, input logic [31:0] rt,
                                    input logic [25:0] imm, input logic pt,
                                    input logic [31:0] pd, input logic [4:0] wn);
    stim_t s;
    s = idle();
    s.vld = 1'b1; s.pc = pc; s.bt = bt; s.rs = rs; s.rt = rt; s.imm = imm;
    s.pt = pt; s.pd = pd; s.wn = wn; s.alu = 32'h1234_5678; s.ck = pc ^ 32'hA5A5_0000;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.vld  = ($urandom_range(0, 4) != 0);
    s.pc   = $urandom & 32'hFFFF_FFFC;
    s.wn   = 5'($urandom);
    case ($urandom_range(0, 3))
      0:       s.rs = 32'd0;
      1:       s.rs = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      default: s.rs = $urandom;
    endcase
    s.rt   = ($urandom_range(0, 2) == 0) ? s.rs : $urandom;
    s.bt   = 4'($urandom_range(0, 15));
    s.imm  = 26'($urandom);
    s.alu  = $urandom;
    s.pt   = 1'($urandom);
    s.pd   = $urandom;
    s.ck   = $urandom;
    s.sba  = ($urandom_range(0, 3) != 0);
    s.flush = ($urandom_range(0, 19) == 0);
    s.exc  = ($urandom_range(0, 19) == 0);
    s.seg  = 7'($urandom);
    if ($urandom_range(0, 1) == 1) s.pd = resolve(s).dest;
    return s;
  endfunction

  // Monitor: compare the DUT against the expectation queued for this cycle.
  always @(negedge clk) begin
    if (rec_q.size() > 0) begin
      mon_r = rec_q.pop_front();
      check("allowin",  {63'd0, exu_allowin}, {63'd0, mon_r.allowin});
      check("valid",    {63'd0, exu_valid},   {63'd0, mon_r.valid});
      check("writeNum", {59'd0, o_wn},        {59'd0, mon_r.regs.wn});
      check("VAddr",    {32'd0, o_pc},        {32'd0, mon_r.regs.pc});
      check("aluRes",   {32'd0, o_alu},       {32'd0, mon_r.regs.alu});
      check("corrDest", {32'd0, o_dest},      {32'd0, mon_r.regs.dest});
      check("corrTake", {63'd0, o_take},      {63'd0, mon_r.regs.take});
      check("repair",   {60'd0, o_rep},       {60'd0, mon_r.regs.rep});
      check("ckpt",     {32'd0, o_ck},        {32'd0, mon_r.regs.ck});
      check("risk",     {63'd0, o_risk},      {63'd0, mon_r.regs.risk});
      check("mispCnt",  {32'd0, o_cnt},       {32'd0, mon_r.cnt});
    end
  end

  initial begin
    stim_t a;
    stim_t b;
    logic [31:0] cnt_save;
    rst = 1'b0;
    {iss_valid, iss_predTake, sba_allowin, sba_flush, cp0_exc} = 5'b0;
    {iss_vaddr, iss_rs, iss_rt, iss_alu, iss_predDest, iss_ckpt} = '0;
    iss_wn = 5'd0; iss_bt = 4'd0; iss_imm = 26'd0; cp0_seg = 7'd0;
    m_full = 1'b0; m_regs = '0; m_cnt = 32'd0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_valid",   {63'd0, exu_valid},   64'd0);
    check("rst_allowin", {63'd0, exu_allowin}, 64'd1);
    check("rst_cnt",     {32'd0, o_cnt},       64'd0);
    check("rst_dest",    {32'd0, o_dest},      64'd0);
    @(negedge clk);
    rst = 1'b1;

    // BEQ taken, predicted not-taken
    drive(br_stim(32'h8000_1000, 4'd1, 32'd5, 32'd5, 26'h0004, 1'b0, 32'd0, 5'd0));
    drive(idle());
    #3;
    check("beq_take", {63'd0, o_take}, 64'd1);
    check("beq_dest", {32'd0, o_dest}, 64'h8000_1014);
    check("beq_rep",  {60'd0, o_rep},  64'h7);
    check("beq_cnt",  {32'd0, o_cnt},  64'd1);

    // BNE not taken, predicted not-taken
    drive(br_stim(32'hBFC0_0000, 4'd2, 32'd7, 32'd7, 26'h0010, 1'b0, 32'd0, 5'd0));
    drive(idle());
    #3;
    check("bne_dest", {32'd0, o_dest}, 64'hBFC0_0008);
    check("bne_rep",  {60'd0, o_rep},  64'h0);
    check("bne_cnt",  {32'd0, o_cnt},  64'd1);

    // JALR correctly predicted
    drive(br_stim(32'h8000_0100, 4'd12, 32'h8000_2000, 32'd0, 26'd0, 1'b1, 32'h8000_2000, 5'd31));
    drive(idle());
    #3;
    check("jalr_alu", {32'd0, o_alu}, 64'h8000_0108);
    check("jalr_rep", {60'd0, o_rep}, 64'h8);
    check("jalr_wn",  {59'd0, o_wn},  64'd31);

    // Full stall for three cycles, then release
    a = br_stim(32'h8000_0200, 4'd9, 32'd0, 32'd0, 26'h12_3456, 1'b1, 32'd0, 5'd3);
    b = br_stim(32'h8000_0204, 4'd0, 32'd0, 32'd0, 26'd0, 1'b0, 32'd0, 5'd4);
    drive(a);
    b.sba = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(b);
      #2;
      check("stall_allowin", {63'd0, exu_allowin}, 64'd0);
      check("stall_hold",    {32'd0, o_pc},        64'h8000_0200);
    end
    b.sba = 1'b1;
    drive(b);
    drive(idle());
    #2;
    check("release_pc", {32'd0, o_pc}, 64'h8000_0204);

    // Back-to-back issue
    for (int i = 0; i < 4; i++) drive(br_stim(32'h8000_0300 + 32'(i * 4), 4'(i + 1), 32'(i), 32'd1, 26'h0020, 1'b1, 32'd0, 5'd1));

    // Flush while holding data and an incoming instruction
    drive(a);
    cnt_save = m_cnt;
    b = br_stim(32'h8000_0400, 4'd1, 32'd1, 32'd1, 26'h0008, 1'b0, 32'd0, 5'd2);
    b.flush = 1'b1;
    drive(b);
    drive(idle());
    #2;
    check("flush_valid", {63'd0, exu_valid}, 64'd0);
    check("flush_pc",    {32'd0, o_pc},      64'd0);
    check("flush_cnt",   {32'd0, o_cnt},     {32'd0, cnt_save});

    // Exception in a younger segment is ignored; in an older one it kills
    b.flush = 1'b0; b.exc = 1'b1; b.seg = 7'b000_0100;
    drive(b);
    a = idle(); a.exc = 1'b1; a.seg = 7'b010_0000;
    drive(a);
    drive(idle());

    // Randomized traffic
    for (int i = 0; i < 1500; i++) drive(rand_stim());
    drive(idle());

    // Saturation: preload counter just below max, then three mispredicts
    @(posedge clk);
    #2;
    dut.mispred_cnt_q = 32'hFFFF_FFFE;
    m_cnt = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) drive(br_stim(32'h8000_0500, 4'd1, 32'd9, 32'd9, 26'h0001, 1'b0, 32'd0, 5'd0));
    drive(idle());
    #2;
    check("sat_cnt", {32'd0, o_cnt}, 64'hFFFF_FFFF);

    // Asynchronous reset in the middle of a stall
    drive(br_stim(32'h8000_0600, 4'd10, 32'd0, 32'd0, 26'h0AB_CDEF, 1'b0, 32'd0, 5'd31));
    a = idle(); a.sba = 1'b0;
    drive(a);
    #6;
    rst = 1'b0;
    #1;
    check("arst_cnt",     {32'd0, o_cnt},       64'd0);
    check("arst_pc",      {32'd0, o_pc},        64'd0);
    check("arst_alu",     {32'd0, o_alu},       64'd0);
    check("arst_valid",   {63'd0, exu_valid},   64'd0);
    check("arst_allowin", {63'd0, exu_allowin}, 64'd1);
    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
